// File: rtl/seq_match_sched.sv
// Round-robin scheduler sharing one serial pattern-match engine between NCH bit sources,
// with a per-channel saturating hit counter.
module seq_match_sched #(
    parameter int                 NCH       = 4,
    parameter int                 FRAME_LEN = 16,
    parameter int                 PAT_LEN   = 6,
    parameter logic [PAT_LEN-1:0] PATTERN   = 6'b111011
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         req,
    input  logic [NCH-1:0]         bit_in,
    output logic [NCH-1:0]         gnt,
    output logic                   match,
    output logic [$clog2(NCH)-1:0] match_ch,
    output logic                   busy,
    output logic [NCH*8-1:0]       match_cnt
);
    localparam int CW = $clog2(NCH);
    localparam int SW = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {IDLE, ARB, RUN, RELEASE} state_t;

    state_t             state;
    logic [CW-1:0]      ptr;
    logic [CW-1:0]      cur;
    logic [PAT_LEN-1:0] window;
    logic [SW-1:0]      count;
    logic [7:0]         cnt [NCH];

    logic [CW-1:0]      pick;
    logic [CW-1:0]      idx;
    logic [PAT_LEN-1:0] win_next;
    logic [SW-1:0]      count_next;
    logic               hit;

    // Scan offsets from farthest to nearest so the nearest requester at or above ptr wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        pick = ptr;
        idx  = '0;
        for (int off = NCH - 1; off >= 0; off--) begin
            idx = CW'((int'(ptr) + off) % NCH);
            if (req[idx]) pick = idx;
        end
    end

    always_comb begin
        win_next   = (window << 1) | PAT_LEN'(bit_in[cur]);
        count_next = count + SW'(1);
        hit        = (count_next >= SW'(PAT_LEN)) && (win_next == PATTERN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            cur      <= '0;
            window   <= '0;
            count    <= '0;
            match    <= 1'b0;
            match_ch <= '0;
            // NOTE: the hit counters are architectural state, so they take the async reset too.
            for (int i = 0; i < NCH; i++) cnt[i] <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same edge.
            match <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) state <= ARB;
                end
                ARB: begin
                    cur    <= pick;
                    window <= '0;
                    count  <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    if (!req[cur]) begin
                        state <= RELEASE;
                    end else begin
                        window <= win_next;
                        count  <= count_next;
                        if (hit) begin
                            match    <= 1'b1;
                            match_ch <= cur;
                            if (cnt[cur] != 8'hFF) cnt[cur] <= cnt[cur] + 8'd1;
                        end
                        if (count_next == SW'(FRAME_LEN)) state <= RELEASE;
                    end
                end
                RELEASE: begin
                    ptr   <= (cur == CW'(NCH - 1)) ? '0 : cur + CW'(1);
                    state <= (|req) ? ARB : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Grant is decoded from state so it drops the instant reset is asserted.
    always_comb begin
        gnt = '0;
        if (state == RUN) gnt[cur] = 1'b1;
    end

    assign busy = (state != IDLE);

    for (genvar i = 0; i < NCH; i++) begin : g_cnt
        assign match_cnt[8*i +: 8] = cnt[i];
    end

endmodule

// File: tb/tb_seq_match_sched.sv
// Bench for seq_match_sched: per-channel bit streams feed the DUT, every cycle is logged,
// and the log is judged against frame-level round-robin and pattern-search expectations.
module tb_seq_match_sched;
    localparam int         NCH       = 4;
    localparam int         FRAME_LEN = 16;
    localparam int         PAT_LEN   = 6;
    localparam logic [5:0] PATTERN   = 6'b111011;
    localparam int         MAXC      = 8192;
    localparam int         STREAM    = 4096;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NCH-1:0]   req = '0;
    logic [NCH-1:0]   bit_in = '0;
    logic [NCH-1:0]   gnt;
    logic             match;
    logic [1:0]       match_ch;
    logic             busy;
    logic [NCH*8-1:0] match_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    seq_match_sched #(
        .NCH(NCH), .FRAME_LEN(FRAME_LEN), .PAT_LEN(PAT_LEN), .PATTERN(PATTERN)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .bit_in(bit_in), .gnt(gnt),
        .match(match), .match_ch(match_ch), .busy(busy), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    // Source behaviour: a channel requests while it has frames left, presents a new bit on
    // every granted cycle, and can be told to drop its request after N samples.
    int             frames_left [NCH];
    int             samp [NCH];
    int             abort_after [NCH];
    int             spos [NCH];
    bit             stream [NCH][STREAM];
    logic [NCH-1:0] prev_gnt;
    int             model_cnt [NCH];

    int             cyc;
    logic [NCH-1:0] gnt_log [MAXC];
    logic [NCH-1:0] req_log [MAXC];
    logic [NCH-1:0] bit_log [MAXC];
    logic           match_log [MAXC];
    logic [1:0]     mch_log [MAXC];
    logic           busy_log [MAXC];
    bit             exp_m [MAXC];
    logic [1:0]     exp_c [MAXC];

    int exp_ch_q [$];
    int exp_len_q [$];
    int exp_gap_q [$];

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < NCH; i++) begin
            if (prev_gnt[i] && !gnt[i] && frames_left[i] > 0) frames_left[i]--;
            if (!gnt[i]) samp[i] = 0;
            if (gnt[i] && abort_after[i] > 0 && samp[i] == abort_after[i]) begin
                frames_left[i] = 0;
                abort_after[i] = 0;
            end
            req[i] = (frames_left[i] > 0);
            if (gnt[i] && req[i]) begin
                bit_in[i] = (spos[i] < STREAM) ? stream[i][spos[i]] : 1'b0;
                spos[i]++;
                samp[i]++;
            end else begin
                bit_in[i] = 1'($urandom);
            end
        end
        prev_gnt = gnt;
        if (cyc < MAXC) begin
            gnt_log[cyc]   = gnt;
            req_log[cyc]   = req;
            bit_log[cyc]   = bit_in;
            match_log[cyc] = match;
            mch_log[cyc]   = match_ch;
            busy_log[cyc]  = busy;
        end
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_env();
        for (int i = 0; i < NCH; i++) begin
            frames_left[i] = 0;
            samp[i]        = 0;
            abort_after[i] = 0;
            spos[i]        = 0;
            model_cnt[i]   = 0;
            for (int j = 0; j < STREAM; j++) stream[i][j] = 1'b0;
        end
        prev_gnt = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_env();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic start_log();
        cyc = 0;
        exp_ch_q.delete();
        exp_len_q.delete();
        exp_gap_q.delete();
    endtask

    task automatic expect_frame(input int ch, input int len, input int gap);
        exp_ch_q.push_back(ch);
        exp_len_q.push_back(len);
        exp_gap_q.push_back(gap);
    endtask

    task automatic load(input int ch, input int start, input logic [15:0] v, input int n);
        for (int j = 0; j < n; j++) stream[ch][start + j] = v[n - 1 - j];
    endtask

    task automatic wait_idle(input string name, input int budget);
        int  n = 0;
        bit  done = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            done = (busy == 1'b0) && (req == '0);
            for (int i = 0; i < NCH; i++) if (frames_left[i] != 0) done = 0;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: still busy after %0d cycles (limit %0d)", name, n, budget);
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // True when the newest PAT_LEN samples of this grant spell PATTERN, oldest first.
    function automatic bit is_hit(input bit smp [$]);
        int s = smp.size();
        if (s < PAT_LEN) return 1'b0;
        for (int j = 0; j < PAT_LEN; j++)
            if (smp[s - PAT_LEN + j] != PATTERN[PAT_LEN - 1 - j]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic analyze(input string name);
        int n = (cyc < MAXC) ? cyc : MAXC;
        int c = 0;
        int fidx = 0;
        int prev_end = -1;
        int first_req = -1;
        int hits [NCH];
        bit smp [$];
        for (int i = 0; i < NCH; i++) hits[i] = 0;
        for (int k = 0; k < n; k++) begin
            exp_m[k] = 1'b0;
            exp_c[k] = 2'd0;
            if (first_req < 0 && req_log[k] != '0) first_req = k;
        end
        while (c < n) begin
            int ch = 0;
            int start;
            int len;
            if (gnt_log[c] == '0) begin
                c++;
                continue;
            end
            n_checks++;
            if ($countones(gnt_log[c]) != 1) begin
                n_fail++;
                $display("FAIL %s_onehot: gnt=%b at cycle %0d, one-hot required", name, gnt_log[c], c);
            end
            for (int i = 0; i < NCH; i++) if (gnt_log[c][i]) ch = i;
            start = c;
            smp.delete();
            while (c < n && gnt_log[c] == gnt_log[start]) begin
                if (req_log[c][ch]) begin
                    smp.push_back(bit_log[c][ch]);
                    if (is_hit(smp) && c + 1 < MAXC) begin
                        exp_m[c + 1] = 1'b1;
                        exp_c[c + 1] = 2'(ch);
                        hits[ch]++;
                    end
                end
                c++;
            end
            len = c - start;
            if (fidx == 0 && first_req >= 0) begin
                n_checks++;
                if (start != first_req + 2) begin
                    n_fail++;
                    $display("FAIL %s_first_grant: grant at cycle %0d, expected %0d", name, start, first_req + 2);
                end
            end
            if (fidx < exp_ch_q.size()) begin
                n_checks++;
                if (ch != exp_ch_q[fidx]) begin
                    n_fail++;
                    $display("FAIL %s_order: frame %0d on ch %0d, expected ch %0d", name, fidx, ch, exp_ch_q[fidx]);
                end
                n_checks++;
                if (len != exp_len_q[fidx]) begin
                    n_fail++;
                    $display("FAIL %s_len: frame %0d lasted %0d, expected %0d", name, fidx, len, exp_len_q[fidx]);
                end
                if (exp_gap_q[fidx] >= 0 && prev_end >= 0) begin
                    n_checks++;
                    if (start - prev_end - 1 != exp_gap_q[fidx]) begin
                        n_fail++;
                        $display("FAIL %s_gap: frame %0d gap %0d, expected %0d", name, fidx,
                                 start - prev_end - 1, exp_gap_q[fidx]);
                    end
                end
            end
            fidx++;
            prev_end = c - 1;
        end
        n_checks++;
        if (fidx != exp_ch_q.size()) begin
            n_fail++;
            $display("FAIL %s_frames: saw %0d frames, expected %0d", name, fidx, exp_ch_q.size());
        end
        for (int k = 0; k < n; k++) begin
            n_checks++;
            if (match_log[k] !== exp_m[k]) begin
                n_fail++;
                $display("FAIL %s_match: cycle %0d match=%b, expected %b", name, k, match_log[k], exp_m[k]);
            end else if (exp_m[k]) begin
                n_checks++;
                if (mch_log[k] !== exp_c[k]) begin
                    n_fail++;
                    $display("FAIL %s_match_ch: cycle %0d ch=%0d, expected %0d", name, k, mch_log[k], exp_c[k]);
                end
            end
        end
        for (int i = 0; i < NCH; i++) begin
            model_cnt[i] = (model_cnt[i] + hits[i] > 255) ? 255 : model_cnt[i] + hits[i];
            n_checks++;
            if (match_cnt[8*i +: 8] !== 8'(model_cnt[i])) begin
                n_fail++;
                $display("FAIL %s_cnt%0d: got %0d expected %0d", name, i, match_cnt[8*i +: 8], model_cnt[i]);
            end
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_val("reset_gnt", 32'(gnt), 32'd0);
        check_val("reset_match", 32'(match), 32'd0);
        check_val("reset_match_ch", 32'(match_ch), 32'd0);
        check_val("reset_busy", 32'(busy), 32'd0);
        check_val("reset_cnt", match_cnt, 32'd0);
    endtask

    task automatic test_single_channel();
        int last = -1;
        do_reset();
        start_log();
        load(0, 0, 16'b111011, 6);
        frames_left[0] = 1;
        expect_frame(0, FRAME_LEN, -1);
        wait_idle("single", 200);
        analyze("single");
        check_val("single_cnt0", 32'(match_cnt[7:0]), 32'd1);
        for (int k = 0; k < cyc && k < MAXC; k++) if (gnt_log[k] != '0) last = k;
        if (last >= 0 && last + 2 < MAXC) begin
            check_val("single_busy_release", 32'(busy_log[last + 1]), 32'd1);
            check_val("single_busy_idle", 32'(busy_log[last + 2]), 32'd0);
        end
    endtask

    task automatic test_overlap();
        do_reset();
        start_log();
        load(2, 0, 16'b1110111011, 10);
        frames_left[2] = 1;
        expect_frame(2, FRAME_LEN, -1);
        wait_idle("overlap", 200);
        analyze("overlap");
        check_val("overlap_cnt2", 32'(match_cnt[23:16]), 32'd2);
    endtask

    task automatic test_back_to_back();
        do_reset();
        start_log();
        for (int i = 0; i < NCH; i++)
            for (int j = 0; j < 2 * FRAME_LEN; j++) stream[i][j] = ($urandom_range(0, 3) != 0);
        frames_left[0] = 2;
        frames_left[1] = 1;
        frames_left[2] = 1;
        frames_left[3] = 1;
        expect_frame(0, FRAME_LEN, -1);
        expect_frame(1, FRAME_LEN, 2);
        expect_frame(2, FRAME_LEN, 2);
        expect_frame(3, FRAME_LEN, 2);
        expect_frame(0, FRAME_LEN, 2);
        wait_idle("b2b", 400);
        analyze("b2b");
    endtask

    task automatic test_abort();
        do_reset();
        start_log();
        load(1, 0, 16'b111011, 6);
        for (int j = 0; j < FRAME_LEN; j++) stream[2][j] = ($urandom_range(0, 3) != 0);
        frames_left[1] = 1;
        frames_left[2] = 1;
        abort_after[1] = 3;
        expect_frame(1, 4, -1);
        expect_frame(2, FRAME_LEN, 2);
        wait_idle("abort", 200);
        frames_left[1] = 1;
        expect_frame(1, FRAME_LEN, -1);
        wait_idle("abort_refill", 200);
        analyze("abort");
        check_val("abort_cnt1", 32'(match_cnt[15:8]), 32'd0);
    endtask

    task automatic test_saturation();
        localparam int NF = 170;
        do_reset();
        start_log();
        for (int j = 0; j < NF * FRAME_LEN; j++) stream[3][j] = PATTERN[5 - (j % 6)];
        frames_left[3] = NF;
        for (int f = 0; f < NF; f++) expect_frame(3, FRAME_LEN, (f == 0) ? -1 : 2);
        wait_idle("sat", NF * (FRAME_LEN + 2) + 100);
        analyze("sat");
        check_val("sat_cnt3", 32'(match_cnt[31:24]), 32'd255);
        check_val("sat_others", 32'(match_cnt[23:0]), 32'd0);
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        do_reset();
        load(0, 0, 16'b111011, 6);
        load(0, FRAME_LEN, 16'b1110, 4);
        frames_left[0] = 2;
        while (!(frames_left[0] == 1 && gnt[0] && samp[0] == 4) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("midrst_reach", 32'(n < 200), 32'd1);
        @(posedge clk);
        #1;
        check_val("midrst_busy_before", 32'(busy), 32'd1);
        check_val("midrst_cnt_before", 32'(match_cnt[7:0]), 32'd1);
        #1 reset = 1'b1;
        #1;
        check_val("midrst_gnt", 32'(gnt), 32'd0);
        check_val("midrst_match", 32'(match), 32'd0);
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_cnt", match_cnt, 32'd0);
        clear_env();
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        start_log();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < FRAME_LEN; j++) stream[i][j] = ($urandom_range(0, 3) != 0);
        frames_left[0] = 1;
        frames_left[1] = 1;
        expect_frame(0, FRAME_LEN, -1);
        expect_frame(1, FRAME_LEN, 2);
        wait_idle("midrst", 200);
        analyze("midrst");
    endtask

    task automatic test_random(input int iter);
        int rem [NCH];
        int p = 0;
        int total = 0;
        do_reset();
        start_log();
        for (int i = 0; i < NCH; i++) begin
            rem[i] = $urandom_range(0, 2);
            for (int j = 0; j < 2 * FRAME_LEN; j++) stream[i][j] = ($urandom_range(0, 3) != 0);
        end
        if (rem[iter % NCH] == 0) rem[iter % NCH] = 1;
        for (int i = 0; i < NCH; i++) frames_left[i] = rem[i];
        // Round-robin over the remaining frame budgets: nearest channel at or after the pointer.
        while (1) begin
            int k = -1;
            for (int off = 0; off < NCH && k < 0; off++)
                if (rem[(p + off) % NCH] > 0) k = (p + off) % NCH;
            if (k < 0) break;
            expect_frame(k, FRAME_LEN, (total == 0) ? -1 : 2);
            rem[k]--;
            total++;
            p = (k + 1) % NCH;
        end
        wait_idle("random", total * (FRAME_LEN + 2) + 100);
        analyze("random");
    endtask

    initial begin
        clear_env();
        cyc = 0;
        test_reset();
        test_single_channel();
        test_overlap();
        test_back_to_back();
        test_abort();
        test_saturation();
        test_reset_mid_frame();
        for (int it = 0; it < 6; it++) test_random(it);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
